// File: rtl/serial_add_pkg.sv
// serial_add_pkg: shared types and constants
// for the bit-serial add sequencer.
package serial_add_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_fa_cell.sv
// serial_fa_cell: single-bit full adder built
// from two half adders and an OR of their carries.
module serial_ha (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

module serial_fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic s0;
  logic c0;
  logic c1;

  serial_ha u_ha0 (
    .a (a),
    .b (b),
    .s (s0),
    .c (c0)
  );

  serial_ha u_ha1 (
    .a (s0),
    .b (ci),
    .s (s),
    .c (c1)
  );

  assign co = c0 | c1;

endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: LSB-first bit-serial adder that
// time-shares one full-adder cell over WIDTH cycles.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [WIDTH-1:0] sh_s;
  logic             c;
  logic [CW-1:0]    cnt;
  logic             s;
  logic             co;
  logic             accept;
  logic             last;

  assign accept = (state == IDLE) && start;
  assign last   = (state == ADD) && (cnt == LAST);

  serial_fa_cell u_cell (
    .a  (sh_a[0]),
    .b  (sh_b[0]),
    .ci (c),
    .s  (s),
    .co (co)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic; the unused encoding falls back to IDLE.
  always_comb begin
    state_nx = IDLE;
    case (state)
      IDLE:    state_nx = start ? ADD : IDLE;
      ADD:     state_nx = last ? DONE : ADD;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Status outputs decoded from the registered state only.
  always_comb begin
    ready = (state == IDLE);
    busy  = (state == ADD) || (state == DONE);
    done  = (state == DONE);
  end

  // Operand/sum shifters, carry flop, bit counter and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_a      <= '0;
      sh_b      <= '0;
      sh_s      <= '0;
      c         <= 1'b0;
      cnt       <= '0;
      sum       <= '0;
      carry_out <= 1'b0;
    end else if (accept) begin
      sh_a <= a;
      sh_b <= b;
      sh_s <= '0;
      c    <= 1'b0;
      cnt  <= '0;
    end else if (state == ADD) begin
      sh_a <= sh_a >> 1;
      sh_b <= sh_b >> 1;
      sh_s <= {s, sh_s[WIDTH-1:1]};
      c    <= co;
      cnt  <= cnt + 1'b1;
      if (last) begin
        sum       <= {s, sh_s[WIDTH-1:1]};
        carry_out <= co;
      end
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: directed and random checks of
// serial_add_ctrl at WIDTH=8 and WIDTH=5.
module tb_serial_add_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       s8 = 1'b0;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic       ready8, busy8, done8, co8;
  logic [7:0] sum8;
  logic       s5 = 1'b0;
  logic [4:0] a5 = '0;
  logic [4:0] b5 = '0;
  logic       ready5, busy5, done5, co5;
  logic [4:0] sum5;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  serial_add_ctrl #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(s8), .a(a8), .b(b8),
    .ready(ready8), .busy(busy8), .done(done8),
    .sum(sum8), .carry_out(co8)
  );

  serial_add_ctrl #(.WIDTH(5)) u5 (
    .clk(clk), .rst(rst), .start(s5), .a(a5), .b(b5),
    .ready(ready5), .busy(busy5), .done(done5),
    .sum(sum5), .carry_out(co5)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [32:0] act,
                     input logic [32:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Transaction-level model: phase 0 idle, 1..W adding,
  // W+1 reporting; result is plain a+b.
  int          wd [2] = '{8, 5};
  int          ph [2] = '{0, 0};
  logic [32:0] res[2] = '{33'd0, 33'd0};
  logic [32:0] xs [2] = '{33'd0, 33'd0};

  function automatic logic st_of(input int d);
    return (d == 0) ? s8 : s5;
  endfunction

  function automatic logic [32:0] ab_of(input int d);
    return (d == 0) ? 33'(a8) + 33'(b8) : 33'(a5) + 33'(b5);
  endfunction

  function automatic logic rdy(input int d);
    return (d == 0) ? ready8 : ready5;
  endfunction

  function automatic logic dn(input int d);
    return (d == 0) ? done8 : done5;
  endfunction

  function automatic logic bz(input int d);
    return (d == 0) ? busy8 : busy5;
  endfunction

  function automatic logic [32:0] out_of(input int d);
    return (d == 0) ? 33'({co8, sum8}) : 33'({co5, sum5});
  endfunction

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        ph[d] = 0;
        xs[d] = '0;
      end else if (ph[d] == 0) begin
        if (st_of(d)) begin
          ph[d]  = 1;
          res[d] = ab_of(d);
        end
      end else if (ph[d] == wd[d] + 1) begin
        ph[d] = 0;
      end else if (ph[d] == wd[d]) begin
        ph[d] = wd[d] + 1;
        xs[d] = res[d];
      end else begin
        ph[d] = ph[d] + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("m%0d_ready", d), 33'(rdy(d)),
            33'(ph[d] == 0));
        chk($sformatf("m%0d_busy", d), 33'(bz(d)),
            33'(ph[d] != 0));
        chk($sformatf("m%0d_done", d), 33'(dn(d)),
            33'(ph[d] == wd[d] + 1));
        chk($sformatf("m%0d_result", d), out_of(d), xs[d]);
      end
    end
  end

  task automatic txn(input int d, input logic [31:0] av,
                     input logic [31:0] bv, output int lat,
                     output logic [32:0] r);
    int k;
    k = 0;
    while (!rdy(d) && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (k >= 40) chk("ready_timeout", 33'(k), 33'd0);
    if (d == 0) begin
      s8 = 1'b1; a8 = av[7:0]; b8 = bv[7:0];
    end else begin
      s5 = 1'b1; a5 = av[4:0]; b5 = bv[4:0];
    end
    @(negedge clk);
    if (d == 0) s8 = 1'b0;
    else        s5 = 1'b0;
    k = 1;
    while (!dn(d) && k < 40) begin
      @(negedge clk);
      k++;
    end
    lat = k;
    r   = out_of(d);
    @(negedge clk);
  endtask

  task automatic run8(input string nm, input logic [7:0] av,
                      input logic [7:0] bv, input logic [8:0] ex);
    int          lat;
    logic [32:0] r;
    txn(0, 32'(av), 32'(bv), lat, r);
    chk({nm, "_lat"}, 33'(lat), 33'd9);
    chk({nm, "_res"}, r, 33'(ex));
    chk({nm, "_pulse"}, 33'(done8), 33'd0);
  endtask

  initial begin
    int          k;
    int          lat;
    bit          seen_idle;
    logic [31:0] ra, rb;
    logic [32:0] r;

    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ready", 33'(ready8), 33'd1);
    chk("rst_busy", 33'(busy8), 33'd0);
    chk("rst_done", 33'(done8), 33'd0);
    chk("rst_sum", 33'(sum8), 33'd0);
    chk("rst_co", 33'(co8), 33'd0);
    rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);

    run8("zero", 8'h00, 8'h00, 9'h000);
    run8("ripple", 8'hFF, 8'h01, 9'h100);
    run8("alt", 8'hA5, 8'h5A, 9'h0FF);
    run8("msb", 8'h80, 8'h80, 9'h100);

    // Held start with operands changing mid-add.
    s8 = 1'b1; a8 = 8'h0F; b8 = 8'h01;
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'hFF;
    k = 1;
    while (!done8 && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("hold_lat", 33'(k), 33'd9);
    chk("hold_res", 33'({co8, sum8}), 33'h010);
    seen_idle = 1'b0;
    while (!(seen_idle && busy8) && k < 40) begin
      @(negedge clk);
      k++;
      if (ready8) seen_idle = 1'b1;
    end
    chk("hold_spacing", 33'(k), 33'd11);
    chk("hold_keep", 33'({co8, sum8}), 33'h010);
    s8 = 1'b0;
    k = 0;
    while (!done8 && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("hold_res2", 33'({co8, sum8}), 33'h1FE);
    @(negedge clk);

    // Reset while the counter reads 3.
    s8 = 1'b1; a8 = 8'h7F; b8 = 8'h7F;
    @(negedge clk);
    s8 = 1'b0;
    repeat (3) begin
      chk("abort_nodone", 33'(done8), 33'd0);
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_done", 33'(done8), 33'd0);
    chk("abort_res", 33'({co8, sum8}), 33'd0);
    chk("abort_ready", 33'(ready8), 33'd1);
    @(negedge clk);
    run8("after_abort", 8'h7F, 8'h7F, 9'h0FE);

    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          ra = $urandom;
          rb = $urandom;
          txn(0, ra, rb, lat, r);
          chk("rnd8_lat", 33'(lat), 33'd9);
          chk("rnd8_res", r, 33'(ra[7:0]) + 33'(rb[7:0]));
        end
      end
      begin
        logic [31:0] qa, qb;
        int          l5;
        logic [32:0] r5;
        for (int j = 0; j < 1000; j++) begin
          qa = $urandom;
          qb = $urandom;
          txn(1, qa, qb, l5, r5);
          chk("rnd5_lat", 33'(l5), 33'd6);
          chk("rnd5_res", r5, 33'(qa[4:0]) + 33'(qb[4:0]));
        end
      end
    join

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
